control_traseu: RTL and testbench

Line-follower decision stage that sits directly upstream of the multiplexed 7-segment display driver.
- Samples three IR line sensors and runs the steering state machine.
- Drives both motor PWM outputs.
- Produces semnal_stanga, semnal_dreapta, stop and the BCD run-time digits (cifra_zeci, cifra_unitati) that the display consumes.

---
 rtl/control_traseu.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_control_traseu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/control_traseu.sv
// Line-follower decision stage: sensor conditioning, steering FSM, motor PWM and run chronometer.
// Optional build macro BLINK_SEMNAL_EN makes active turn indicators blink every TICK_DIV/2 cycles.
module control_traseu #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned LOST_LIMIT = 25000000,
    parameter int unsigned PWM_PERIOD = 256,
    parameter int unsigned DUTY_FULL  = 200,
    parameter int unsigned DUTY_TURN  = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       senzor_stanga,
    input  logic       senzor_centru,
    input  logic       senzor_dreapta,
    output logic       motor_stanga,
    output logic       motor_dreapta,
    output logic       semnal_stanga,
    output logic       semnal_dreapta,
    output logic       stop,
    output logic [3:0] cifra_zeci,
    output logic [3:0] cifra_unitati
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LW = (LOST_LIMIT > 1) ? $clog2(LOST_LIMIT) : 1;
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned PW = $clog2(PWM_PERIOD + 1);

    localparam logic DIR_STANGA  = 1'b0;
    localparam logic DIR_DREAPTA = 1'b1;

    localparam logic [PW-1:0] DUTY_FULL_C = PW'(DUTY_FULL);
    localparam logic [PW-1:0] DUTY_TURN_C = PW'(DUTY_TURN);

    typedef enum logic [2:0] {
        OPRIT   = 3'd0,
        INAINTE = 3'd1,
        STANGA  = 3'd2,
        DREAPTA = 3'd3,
        CAUTARE = 3'd4
    } state_t;

    // Saturating two-digit BCD increment; 99 holds.
    function automatic logic [7:0] bcd_inc(input logic [3:0] zeci, input logic [3:0] unit);
        logic [7:0] res;
        if ((zeci >= 4'd9) && (unit >= 4'd9)) begin
            res = {4'd9, 4'd9};
        end else if (unit >= 4'd9) begin
            res = {zeci + 4'd1, 4'd0};
        end else begin
            res = {zeci, unit + 4'd1};
        end
        return res;
    endfunction

    logic [2:0]    sens_meta_q, sens_sync_q;
    logic          start_meta_q, start_sync_q, start_prev_q;
    logic [2:0]    cand_q, cand_d, filt_q, filt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    state_t        state_q, state_d;
    logic          last_dir_q, last_dir_d;
    logic [LW-1:0] lost_q, lost_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [3:0]    zeci_q, zeci_d, unit_q, unit_d;
    logic [PW-1:0] pwm_q, pwm_d;
    logic [PW-1:0] duty_l_s, duty_r_s;
    logic          start_ok_s;
    logic          turn_l_s, turn_r_s;
    logic          blink_on_s;

    assign start_ok_s = start_sync_q & ~start_prev_q & (filt_q != 3'b111);

    // Debounce: a new synchronized vector must repeat DEB_CYCLES times before it is accepted.
    always_comb begin
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        filt_d    = filt_q;
        if (sens_sync_q == filt_q) begin
            cand_d    = filt_q;
            deb_cnt_d = '0;
        end else if ((sens_sync_q == cand_q) && (deb_cnt_q != '0)) begin
            if (deb_cnt_q >= DW'(DEB_CYCLES - 1)) begin
                filt_d    = sens_sync_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end else begin
            cand_d = sens_sync_q;
            if (DEB_CYCLES <= 1) begin
                filt_d    = sens_sync_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = DW'(1);
            end
        end
    end

    // Steering FSM next state, last turn direction and lost-line counter.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        lost_d     = '0;
        case (state_q)
            OPRIT: begin
                if (start_ok_s) begin
                    state_d = INAINTE;
                end else begin
                    state_d = OPRIT;
                end
            end
            INAINTE, STANGA, DREAPTA, CAUTARE: begin
                case (filt_q)
                    3'b111: state_d = OPRIT;
                    3'b010: state_d = INAINTE;
                    3'b100, 3'b110: begin
                        state_d    = STANGA;
                        last_dir_d = DIR_STANGA;
                    end
                    3'b001, 3'b011: begin
                        state_d    = DREAPTA;
                        last_dir_d = DIR_DREAPTA;
                    end
                    3'b000: begin
                        if (state_q != CAUTARE) begin
                            state_d = CAUTARE;
                        end else if (lost_q >= LW'(LOST_LIMIT - 1)) begin
                            state_d = OPRIT;
                        end else begin
                            state_d = CAUTARE;
                            lost_d  = lost_q + LW'(1);
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
            default: state_d = OPRIT;
        endcase
    end

    // Chronometer: prescaler runs only outside OPRIT; a fresh start clears it.
    always_comb begin
        presc_d = presc_q;
        zeci_d  = zeci_q;
        unit_d  = unit_q;
        if (state_q == OPRIT) begin
            if (start_ok_s) begin
                presc_d = '0;
                zeci_d  = 4'd0;
                unit_d  = 4'd0;
            end else begin
                presc_d = presc_q;
            end
        end else if (presc_q >= TW'(TICK_DIV - 1)) begin
            presc_d          = '0;
            {zeci_d, unit_d} = bcd_inc(zeci_q, unit_q);
        end else begin
            presc_d = presc_q + TW'(1);
        end
    end

    // Free-running PWM counter.
    always_comb begin
        if (pwm_q >= PW'(PWM_PERIOD - 1)) begin
            pwm_d = '0;
        end else begin
            pwm_d = pwm_q + PW'(1);
        end
    end

    // Register bank for everything above.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sens_meta_q  <= 3'b000;
            sens_sync_q  <= 3'b000;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            cand_q       <= 3'b000;
            filt_q       <= 3'b000;
            deb_cnt_q    <= '0;
            state_q      <= OPRIT;
            last_dir_q   <= DIR_STANGA;
            lost_q       <= '0;
            presc_q      <= '0;
            zeci_q       <= 4'd0;
            unit_q       <= 4'd0;
            pwm_q        <= '0;
        end else begin
            sens_meta_q  <= {senzor_stanga, senzor_centru, senzor_dreapta};
            sens_sync_q  <= sens_meta_q;
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            cand_q       <= cand_d;
            filt_q       <= filt_d;
            deb_cnt_q    <= deb_cnt_d;
            state_q      <= state_d;
            last_dir_q   <= last_dir_d;
            lost_q       <= lost_d;
            presc_q      <= presc_d;
            zeci_q       <= zeci_d;
            unit_q       <= unit_d;
            pwm_q        <= pwm_d;
        end
    end

`ifdef BLINK_SEMNAL_EN
    localparam int unsigned HALF = ((TICK_DIV / 2) > 0) ? (TICK_DIV / 2) : 1;
    localparam int unsigned HW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [HW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          turning_q_s, turning_d_s;

    assign turning_q_s = (state_q == STANGA) || (state_q == DREAPTA) || (state_q == CAUTARE);
    assign turning_d_s = (state_d == STANGA) || (state_d == DREAPTA) || (state_d == CAUTARE);

    // Blink phase restarts lit whenever a turning state is newly entered.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (turning_d_s && (state_d != state_q)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (turning_q_s) begin
            if (blink_cnt_q >= HW'(HALF - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + HW'(1);
            end
        end else begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end
    end

    // Blink phase registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_on_s = phase_q;
`else
    assign blink_on_s = 1'b1;
`endif

    // Output decode straight from the state register, so reset clears them at once.
    always_comb begin
        duty_l_s = '0;
        duty_r_s = '0;
        turn_l_s = 1'b0;
        turn_r_s = 1'b0;
        stop     = 1'b0;
        case (state_q)
            INAINTE: begin
                duty_l_s = DUTY_FULL_C;
                duty_r_s = DUTY_FULL_C;
            end
            STANGA: begin
                duty_l_s = DUTY_TURN_C;
                duty_r_s = DUTY_FULL_C;
                turn_l_s = 1'b1;
            end
            DREAPTA: begin
                duty_l_s = DUTY_FULL_C;
                duty_r_s = DUTY_TURN_C;
                turn_r_s = 1'b1;
            end
            CAUTARE: begin
                if (last_dir_q == DIR_STANGA) begin
                    duty_r_s = DUTY_TURN_C;
                    turn_l_s = 1'b1;
                end else begin
                    duty_l_s = DUTY_TURN_C;
                    turn_r_s = 1'b1;
                end
            end
            default: stop = 1'b1;
        endcase
    end

    assign motor_stanga   = (pwm_q < duty_l_s);
    assign motor_dreapta  = (pwm_q < duty_r_s);
    assign semnal_stanga  = turn_l_s & blink_on_s;
    assign semnal_dreapta = turn_r_s & blink_on_s;
    assign cifra_zeci     = zeci_q;
    assign cifra_unitati  = unit_q;

endmodule

// File: tb/tb_control_traseu.sv
// Scoreboard bench for control_traseu: timed expectations queued by the stimulus, checked by a monitor.
module tb_control_traseu;

    logic       clock = 1'b0;
    logic       reset, start, ss, sc, sd;
    logic       motor_stanga, motor_dreapta, semnal_stanga, semnal_dreapta, stop;
    logic [3:0] cifra_zeci, cifra_unitati;

    control_traseu #(
        .TICK_DIV(10), .DEB_CYCLES(2), .LOST_LIMIT(20),
        .PWM_PERIOD(8), .DUTY_FULL(6), .DUTY_TURN(3)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .senzor_stanga(ss), .senzor_centru(sc), .senzor_dreapta(sd),
        .motor_stanga(motor_stanga), .motor_dreapta(motor_dreapta),
        .semnal_stanga(semnal_stanga), .semnal_dreapta(semnal_dreapta),
        .stop(stop), .cifra_zeci(cifra_zeci), .cifra_unitati(cifra_unitati)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    localparam int K_STAT = 1;
    localparam int K_DIG  = 2;
    localparam int K_DUTY = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          a;
        int          b;
        int          c;
        logic [63:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] ml_hist = 8'h00;
    logic [7:0] mr_hist = 8'h00;

    task automatic push(input int at, input int kind, input logic [63:0] tag,
                        input int a, input int b, input int c);
        exp_t x;
        x.cyc = at; x.kind = kind; x.a = a; x.b = b; x.c = c; x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic exp_stat(input int at, input logic [63:0] tag, input int st, input int sl, input int sr);
        push(at, K_STAT, tag, st, sl, sr);
    endtask

    task automatic exp_dig(input int at, input logic [63:0] tag, input int z, input int u);
        push(at, K_DIG, tag, z, u, 0);
    endtask

    task automatic exp_duty(input int at, input logic [63:0] tag, input int l, input int r);
        push(at, K_DUTY, tag, l, r, 0);
    endtask

    task automatic chk(input logic [63:0] tag, input string fld, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s.%s at cycle %0d: got %0d expected %0d", tag, fld, cyc, act, expv);
        end
    endtask

    // Monitor: keeps an 8-sample motor history and compares every expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            ml_hist = {ml_hist[6:0], motor_stanga};
            mr_hist = {mr_hist[6:0], motor_dreapta};
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    e = sb_q[i];
                    sb_q.delete(i);
                    if (e.kind == K_STAT) begin
                        chk(e.tag, "stop", int'(stop), e.a);
                        chk(e.tag, "sem_l", int'(semnal_stanga), e.b);
                        chk(e.tag, "sem_r", int'(semnal_dreapta), e.c);
                    end else if (e.kind == K_DIG) begin
                        chk(e.tag, "zeci", int'(cifra_zeci), e.a);
                        chk(e.tag, "unit", int'(cifra_unitati), e.b);
                    end else begin
                        chk(e.tag, "duty_l", $countones(ml_hist), e.a);
                        chk(e.tag, "duty_r", $countones(mr_hist), e.b);
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_v(input logic [2:0] v);
        {ss, sc, sd} = v;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ss = 1'b0; sc = 1'b0; sd = 1'b0;
        wait_until(2);
        exp_stat(2, "rst", 1, 0, 0);
        exp_dig(2, "rst", 0, 0);
        exp_duty(2, "rst", 0, 0);
        wait_until(3);
        reset = 1'b0;

        // 1: start with centre line, straight run and chronometer
        set_v(3'b010);
        exp_stat(14, "t1pre", 1, 0, 0);
        exp_stat(15, "t1run", 0, 0, 0);
        exp_dig(24, "t1d0", 0, 0);
        exp_dig(25, "t1d1", 0, 1);
        exp_dig(45, "t1d3", 0, 3);
        exp_duty(27, "t1pwm", 6, 6);
        wait_until(12); start = 1'b1;
        wait_until(17); start = 1'b0;

        // 2: left then right turns, latency 5
        exp_stat(54, "t2pre", 0, 0, 0);
        exp_stat(55, "t2left", 0, 1, 0);
        exp_duty(64, "t2pwm", 3, 6);
        exp_stat(70, "t2right", 0, 0, 1);
        exp_duty(79, "t2pwm2", 6, 3);
        exp_stat(85, "t2left2", 0, 1, 0);
        wait_until(50); set_v(3'b100);
        wait_until(65); set_v(3'b011);
        wait_until(80); set_v(3'b110);

        // 3: line lost after a left turn, forced stop after 20 cycles
        exp_stat(95, "t3srch", 0, 1, 0);
        exp_duty(104, "t3pwm", 0, 3);
        exp_stat(114, "t3lost", 0, 1, 0);
        exp_stat(115, "t3stop", 1, 0, 0);
        exp_dig(115, "t3frz", 1, 0);
        exp_duty(124, "t3off", 0, 0);
        exp_dig(150, "t3frz2", 1, 0);
        wait_until(90); set_v(3'b000);

        // 4: restart, short losses clear the lost counter
        exp_stat(168, "t4run", 0, 0, 0);
        exp_dig(168, "t4clr", 0, 0);
        exp_stat(180, "t4srch", 0, 1, 0);
        exp_stat(190, "t4back", 0, 0, 0);
        exp_stat(212, "t4mid", 0, 1, 0);
        exp_stat(218, "t4srch2", 0, 1, 0);
        exp_stat(219, "t4nostop", 0, 0, 0);
        wait_until(155); set_v(3'b010);
        wait_until(165); start = 1'b1;
        wait_until(170); start = 1'b0;
        wait_until(175); set_v(3'b000);
        wait_until(185); set_v(3'b010);
        wait_until(195); set_v(3'b000);
        wait_until(214); set_v(3'b010);

        // 5: saturation, finish bar, start ignored on bar, restart clears digits
        exp_dig(1157, "t5d98", 9, 8);
        exp_dig(1158, "t5d99", 9, 9);
        exp_dig(1240, "t5sat", 9, 9);
        exp_stat(1254, "t5pre", 0, 0, 0);
        exp_stat(1255, "t5fin", 1, 0, 0);
        exp_stat(1275, "t5ign", 1, 0, 0);
        exp_dig(1275, "t5hold", 9, 9);
        exp_stat(1293, "t5go", 0, 0, 0);
        exp_dig(1293, "t5clr", 0, 0);
        wait_until(1250); set_v(3'b111);
        wait_until(1265); start = 1'b1;
        wait_until(1270); start = 1'b0;
        wait_until(1280); set_v(3'b010);
        wait_until(1290); start = 1'b1;
        wait_until(1295); start = 1'b0;

        // 6: asynchronous reset mid-turn, then a one-cycle sensor glitch
        exp_stat(1309, "t6left", 0, 1, 0);
        exp_stat(1310, "t6rst", 1, 0, 0);
        exp_dig(1310, "t6rstd", 0, 0);
        exp_duty(1318, "t6off", 0, 0);
        exp_stat(1326, "t6post", 1, 0, 0);
        exp_stat(1343, "t6run", 0, 0, 0);
        exp_stat(1360, "t6glitch", 0, 0, 0);
        wait_until(1300); set_v(3'b100);
        wait_until(1310); reset = 1'b1;
        wait_until(1320); reset = 1'b0;
        wait_until(1330); set_v(3'b010);
        wait_until(1340); start = 1'b1;
        wait_until(1345); start = 1'b0;
        wait_until(1350); set_v(3'b100);
        wait_until(1351); set_v(3'b010);

        wait_until(1370);
        @(negedge clock);
        #1;
        foreach (sb_q[i]) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for cycle %0d never compared, required kind %0d", sb_q[i].tag, sb_q[i].cyc, sb_q[i].kind);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
